// File: rtl/sm_div_seq_pkg.sv
// Shared definitions for the sign-magnitude sequential divider:
// FSM encoding, default magnitude widths and the no-negative-zero helper.
package sm_div_seq_pkg;

  localparam int DEF_MAG_A = 4;
  localparam int DEF_MAG_B = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // A zero magnitude always reports a positive sign.
  function automatic logic zero_sign(input logic sign, input logic is_zero);
    return sign & ~is_zero;
  endfunction

endpackage

// File: rtl/sm_div_seq_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// subtract the divisor when it fits, report the quotient bit.
module sm_div_step #(
  parameter int MAG_B = 2
) (
  input  logic [MAG_B:0]   pr_in,
  input  logic             din,
  input  logic [MAG_B-1:0] divisor,
  output logic [MAG_B:0]   pr_out,
  output logic             q_bit
);

  logic [MAG_B:0] shifted;
  logic [MAG_B:0] div_ext;

  // The bit shifted out of the top stands for 2^(MAG_B+1), so it forces a
  // subtract; the modular difference is still the correct remainder.
  always_comb begin
    shifted = {pr_in[MAG_B-1:0], din};
    div_ext = {1'b0, divisor};
    q_bit   = pr_in[MAG_B] | (shifted >= div_ext);
    pr_out  = q_bit ? (shifted - div_ext) : shifted;
  end

endmodule

// File: rtl/sm_div_seq.sv
// Sequential sign-magnitude restoring divider with start/done handshake.
// Define SM_DIV_FLAGS_EN to build the zf/ef/of quotient flag registers.
module sm_div_seq
  import sm_div_seq_pkg::*;
#(
  parameter int MAG_A = DEF_MAG_A,
  parameter int MAG_B = DEF_MAG_B
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             a_sign,
  input  logic [MAG_A-1:0] a_mag,
  input  logic             b_sign,
  input  logic [MAG_B-1:0] b_mag,
  output logic             busy,
  output logic             done,
  output logic             q_sign,
  output logic [MAG_A-1:0] q_mag,
  output logic             r_sign,
  output logic [MAG_B-1:0] r_mag,
  output logic             dz,
  output logic             zf,
  output logic             ef,
  output logic             of,
  output logic [1:0]       dbg_state
);

  // Handshake: start is honoured only in IDLE (the accepting edge is E0);
  // busy is high while stepping, done pulses for exactly one cycle.
  localparam int CW = $clog2(MAG_A + 1);
  localparam logic [CW-1:0] LAST = CW'(MAG_A - 1);

  state_t           state, state_nx;
  logic [CW-1:0]    cnt;
  logic [MAG_A-1:0] div_sr;
  logic [MAG_A-1:0] quo_sr;
  logic [MAG_A-1:0] quo_nx;
  logic [MAG_B:0]   rem;
  logic [MAG_B:0]   rem_nx;
  logic [MAG_B-1:0] b_reg;
  logic             sa_reg;
  logic             sq_reg;
  logic             q_bit;
  logic             accept;
  logic             b_zero;
  logic             last_step;

  assign accept    = (state == ST_IDLE) && start;
  assign b_zero    = (b_mag == '0);
  assign last_step = (state == ST_CALC) && (cnt == LAST);
  assign quo_nx    = {quo_sr[MAG_A-2:0], q_bit};

  sm_div_step #(.MAG_B(MAG_B)) u_step (
    .pr_in   (rem),
    .din     (div_sr[MAG_A-1]),
    .divisor (b_reg),
    .pr_out  (rem_nx),
    .q_bit   (q_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (start) state_nx = b_zero ? ST_DONE : ST_CALC;
      ST_CALC: if (cnt == LAST) state_nx = ST_DONE;
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  assign busy      = (state == ST_CALC);
  assign done      = (state == ST_DONE);
  assign dbg_state = state;

  // Working registers plus result registers; results hold until rewritten.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      div_sr <= '0;
      quo_sr <= '0;
      rem    <= '0;
      b_reg  <= '0;
      sa_reg <= 1'b0;
      sq_reg <= 1'b0;
      q_sign <= 1'b0;
      q_mag  <= '0;
      r_sign <= 1'b0;
      r_mag  <= '0;
      dz     <= 1'b0;
    end else if (accept) begin
      cnt    <= '0;
      div_sr <= a_mag;
      quo_sr <= '0;
      rem    <= '0;
      b_reg  <= b_mag;
      sa_reg <= a_sign;
      sq_reg <= a_sign ^ b_sign;
      dz     <= b_zero;
      if (b_zero) begin
        q_sign <= 1'b0;
        q_mag  <= '0;
        r_mag  <= a_mag[MAG_B-1:0];
        r_sign <= zero_sign(a_sign, a_mag[MAG_B-1:0] == '0);
      end
    end else if (state == ST_CALC) begin
      cnt    <= cnt + 1'b1;
      div_sr <= {div_sr[MAG_A-2:0], 1'b0};
      quo_sr <= quo_nx;
      rem    <= rem_nx;
      if (last_step) begin
        q_mag  <= quo_nx;
        q_sign <= zero_sign(sq_reg, quo_nx == '0);
        r_mag  <= rem_nx[MAG_B-1:0];
        r_sign <= zero_sign(sa_reg, rem_nx[MAG_B-1:0] == '0);
      end
    end
  end

`ifdef SM_DIV_FLAGS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      zf <= 1'b0;
      ef <= 1'b0;
      of <= 1'b0;
    end else if (accept && b_zero) begin
      zf <= 1'b1;
      ef <= 1'b1;
      of <= 1'b0;
    end else if (last_step) begin
      zf <= (quo_nx == '0);
      ef <= ~quo_nx[0];
      of <= quo_nx[0];
    end
  end
`else
  assign zf = 1'b0;
  assign ef = 1'b0;
  assign of = 1'b0;
`endif

endmodule

// File: tb/tb_sm_div_seq.sv
// Self-checking bench for sm_div_seq: arithmetic reference model checked every
// cycle, plus directed cases with hand-computed literal results.
module tb_sm_div_seq;

  localparam int MAG_A = 4;
  localparam int MAG_B = 2;
`ifdef SM_DIV_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       a_sign = 1'b0;
  logic [3:0] a_mag = '0;
  logic       b_sign = 1'b0;
  logic [1:0] b_mag = '0;
  logic       busy, done, q_sign, r_sign, dz, zf, ef, of;
  logic [3:0] q_mag;
  logic [1:0] r_mag;
  logic [1:0] dbg_state;

  int tests = 0;
  int fails = 0;

  sm_div_seq #(.MAG_A(MAG_A), .MAG_B(MAG_B)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a_sign    (a_sign),
    .a_mag     (a_mag),
    .b_sign    (b_sign),
    .b_mag     (b_mag),
    .busy      (busy),
    .done      (done),
    .q_sign    (q_sign),
    .q_mag     (q_mag),
    .r_sign    (r_sign),
    .r_mag     (r_mag),
    .dz        (dz),
    .zf        (zf),
    .ef        (ef),
    .of        (of),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: m_cnt = -1 idle, >0 edges left until done, 0 = done cycle.
  int   m_cnt = -1;
  bit   checking = 1'b0;
  logic e_qs, e_rs, e_dz, e_zf, e_ef, e_of;
  logic [3:0] e_qm;
  logic [1:0] e_rm;
  int   p_qm, p_rm;
  logic p_qs, p_rs;

  always @(posedge clk) begin
    if (rst) begin
      m_cnt = -1;
      {e_qs, e_rs, e_dz, e_zf, e_ef, e_of} = '0;
      e_qm = '0;
      e_rm = '0;
      checking = 1'b1;
    end else if (m_cnt == -1) begin
      if (start) begin
        if (b_mag == 0) begin
          e_dz  = 1'b1;
          e_qs  = 1'b0;
          e_qm  = '0;
          e_rm  = 2'(int'(a_mag) % 4);
          e_rs  = a_sign && (int'(a_mag) % 4 != 0);
          e_zf  = FLAGS;
          e_ef  = FLAGS;
          e_of  = 1'b0;
          m_cnt = 0;
        end else begin
          e_dz  = 1'b0;
          p_qm  = int'(a_mag) / int'(b_mag);
          p_rm  = int'(a_mag) % int'(b_mag);
          p_qs  = (a_sign ^ b_sign) && (p_qm != 0);
          p_rs  = a_sign && (p_rm != 0);
          m_cnt = MAG_A;
        end
      end
    end else if (m_cnt == 0) begin
      m_cnt = -1;
    end else begin
      m_cnt--;
      if (m_cnt == 0) begin
        e_qm = 4'(p_qm);
        e_rm = 2'(p_rm);
        e_qs = p_qs;
        e_rs = p_rs;
        e_zf = FLAGS && (p_qm == 0);
        e_ef = FLAGS && (p_qm % 2 == 0);
        e_of = FLAGS && (p_qm % 2 == 1);
      end
    end
  end

  // scoreboard compare, every cycle after the first reset edge
  always @(negedge clk) begin
    if (checking) begin
      check("busy",   busy,   32'(m_cnt > 0));
      check("done",   done,   32'(m_cnt == 0));
      check("dz",     dz,     e_dz);
      check("q_sign", q_sign, e_qs);
      check("q_mag",  q_mag,  e_qm);
      check("r_sign", r_sign, e_rs);
      check("r_mag",  r_mag,  e_rm);
      check("zf",     zf,     e_zf);
      check("ef",     ef,     e_ef);
      check("of",     of,     e_of);
    end
  end

  // driver tasks
  task automatic wait_done(output int lat);
    lat = 0;
    while (done !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (done !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: got no done, expected done within 20 cycles");
    end
  endtask

  task automatic run_op(input logic as, input logic [3:0] am, input logic bs,
                        input logic [1:0] bm, output int lat);
    @(negedge clk);
    a_sign = as; a_mag = am; b_sign = bs; b_mag = bm; start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    a_sign = 1'($urandom_range(0, 1));
    a_mag  = 4'($urandom_range(0, 15));
    b_sign = 1'($urandom_range(0, 1));
    b_mag  = 2'($urandom_range(0, 3));
    wait_done(lat);
  endtask

  int lat;

  initial begin
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_q_mag", q_mag, 0);
    check("rst_dz", dz, 0);
    rst = 1'b0;

    // +15 / +3
    run_op(1'b0, 4'd15, 1'b0, 2'd3, lat);
    check("t1_lat", lat, 4);
    check("t1_q_sign", q_sign, 0);
    check("t1_q_mag", q_mag, 5);
    check("t1_r_sign", r_sign, 0);
    check("t1_r_mag", r_mag, 0);
    check("t1_dz", dz, 0);
    check("t1_zf", zf, 0);
    check("t1_ef", ef, 0);
    check("t1_of", of, 32'(FLAGS));

    // -9 / +2
    run_op(1'b1, 4'd9, 1'b0, 2'd2, lat);
    check("t2_q_sign", q_sign, 1);
    check("t2_q_mag", q_mag, 4);
    check("t2_r_sign", r_sign, 1);
    check("t2_r_mag", r_mag, 1);
    check("t2_ef", ef, 32'(FLAGS));

    // -2 / -3: zero quotient loses its sign
    run_op(1'b1, 4'd2, 1'b1, 2'd3, lat);
    check("t3_q_sign", q_sign, 0);
    check("t3_q_mag", q_mag, 0);
    check("t3_r_sign", r_sign, 1);
    check("t3_r_mag", r_mag, 2);
    check("t3_zf", zf, 32'(FLAGS));
    check("t3_ef", ef, 32'(FLAGS));

    // +7 / -0 then +6 / +3
    run_op(1'b0, 4'd7, 1'b1, 2'd0, lat);
    check("t4_lat", lat, 0);
    check("t4_dz", dz, 1);
    check("t4_q_sign", q_sign, 0);
    check("t4_q_mag", q_mag, 0);
    check("t4_r_sign", r_sign, 0);
    check("t4_r_mag", r_mag, 3);
    check("t4_zf", zf, 32'(FLAGS));
    run_op(1'b0, 4'd6, 1'b0, 2'd3, lat);
    check("t4b_dz", dz, 0);
    check("t4b_q_mag", q_mag, 2);
    repeat (3) @(negedge clk);
    check("t4b_hold_q_mag", q_mag, 2);
    check("t4b_hold_done", done, 0);

    // start re-pulsed during CALC is ignored
    @(negedge clk);
    a_sign = 1'b0; a_mag = 4'd15; b_sign = 1'b0; b_mag = 2'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a_sign = 1'b1; a_mag = 4'd9; b_mag = 2'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    check("t5_q_mag", q_mag, 5);
    check("t5_q_sign", q_sign, 0);
    check("t5_r_mag", r_mag, 0);
    repeat (3) @(negedge clk);
    check("t5_no_second_done", done, 0);

    // rst at step 2
    @(negedge clk);
    a_sign = 1'b0; a_mag = 4'd15; b_sign = 1'b0; b_mag = 2'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("t5_rst_no_done", done, 0);
      @(negedge clk);
    end
    check("t5_rst_q_mag", q_mag, 0);
    check("t5_rst_r_mag", r_mag, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_dz", dz, 0);

    // exhaustive sweep, checked by the model every cycle
    for (int ai = 0; ai < 32; ai++) begin
      for (int bi = 0; bi < 8; bi++) begin
        run_op(1'(ai >> 4), 4'(ai), 1'(bi >> 2), 2'(bi), lat);
      end
    end
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
